// File: rtl/data_memory_pkg.sv
// +----------------------------------------------------------------------------
// | data_memory_pkg : shared defaults and index/preload helpers for data_memory
// | Revision 1.0
// +----------------------------------------------------------------------------
`default_nettype none

package data_memory_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;
  localparam int DEPTH_DEF  = 64;

  // Helpers work on a 64-bit carrier so any ADDR_W/DATA_W up to 64 fits.
  function automatic logic [63:0] word_index(input logic [63:0] byte_addr);
    return byte_addr >> 2;
  endfunction

  function automatic logic [63:0] preload_value(input int unsigned idx);
    return 64'(idx);
  endfunction

  function automatic logic is_misaligned(input logic [1:0] byte_lsbs);
    return |byte_lsbs;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_word_array.sv
// +----------------------------------------------------------------------------
// | mem_word_array : word storage with async-reset preload and one write port
// | Revision 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module mem_word_array
  import data_memory_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int IDX_W  = $clog2(DEPTH_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] w_words [DEPTH];

  // Each word is its own register so reset can load a distinct preload value.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    localparam logic [DATA_W-1:0] c_PRELOAD = DATA_W'(preload_value(i));
    localparam logic [IDX_W-1:0]  c_MY_IDX  = IDX_W'(i);

    logic [DATA_W-1:0] r_word;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_word <= c_PRELOAD;
      end else if (wr_en && (wr_idx == c_MY_IDX)) begin
        r_word <= wr_data;
      end
    end

    assign w_words[i] = r_word;
  end

  assign rd_data = w_words[rd_idx];

endmodule

`default_nettype wire

// File: rtl/data_memory.sv
// +----------------------------------------------------------------------------
// | data_memory : byte-addressed word RAM, async read, sync write, range check
// | Revision 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module data_memory
  import data_memory_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              addr_err
);

  localparam int c_IDX_W = $clog2(DEPTH);

  logic [63:0]         w_word_full;
  logic [c_IDX_W-1:0]  w_idx;
  logic                w_in_range;
  logic                w_misaligned;
  logic                w_wr_en;
  logic [DATA_W-1:0]   w_rd_word;

  // Range is judged on the full word index so high address bits never alias.
  assign w_word_full  = word_index(64'(address));
  assign w_in_range   = (w_word_full < 64'(DEPTH));
  assign w_idx        = w_word_full[c_IDX_W-1:0];
  assign w_misaligned = is_misaligned(address[1:0]);
  assign w_wr_en      = write & w_in_range;

  mem_word_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (c_IDX_W)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (w_wr_en),
    .wr_idx  (w_idx),
    .wr_data (write_data),
    .rd_idx  (w_idx),
    .rd_data (w_rd_word)
  );

  assign read_data = w_in_range ? w_rd_word : '0;
  assign addr_err  = w_misaligned | ~w_in_range;

endmodule

`default_nettype wire

// File: tb/tb_data_memory.sv
// +----------------------------------------------------------------------------
// | tb_data_memory : scoreboard bench for data_memory against an array model
// | Revision 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module tb_data_memory;

  localparam int DEPTH = 64;

  logic        clk;
  logic        rst_n;
  logic        write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        addr_err;

  data_memory #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .write      (write),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .addr_err   (addr_err)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic [31:0] addr;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  logic [31:0] model [DEPTH];
  int          checks = 0;
  int          errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs are settled by the falling edge of each cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      checks++;
      if (read_data !== cur.data || addr_err !== cur.err) begin
        errors++;
        $display("FAIL %s addr=%h: got data=%h err=%b, expected data=%h err=%b",
                 cur.tag, cur.addr, read_data, addr_err, cur.data, cur.err);
      end
    end
  end

  task automatic reset_model();
    for (int i = 0; i < DEPTH; i++) model[i] = i;
  endtask

  task automatic push_expect(input string tag);
    exp_t        e;
    int unsigned w;
    w = address >> 2;
    e.addr = address;
    e.tag  = tag;
    e.data = (w < DEPTH) ? model[w] : 32'h0;
    e.err  = (address[1:0] != 2'b00) || (w >= DEPTH);
    sb.push_back(e);
  endtask

  task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input string tag);
    int unsigned idx;
    @(posedge clk);
    #1;
    write      = w;
    address    = a;
    write_data = d;
    push_expect(tag);
    idx = a >> 2;
    if (rst_n && w && idx < DEPTH) model[idx] = d;
  endtask

  task automatic reset_mid(input logic [31:0] a, input string tag);
    @(posedge clk);
    #3;
    write   = 1'b0;
    address = a;
    rst_n   = 1'b0;
    reset_model();
    push_expect(tag);
  endtask

  task automatic release_rst(input logic [31:0] a, input string tag);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    write   = 1'b0;
    address = a;
    push_expect(tag);
  endtask

  initial begin
    logic [31:0] a;
    rst_n      = 1'b1;
    write      = 1'b0;
    address    = 32'd0;
    write_data = 32'd0;
    reset_model();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);

    release_rst(32'd12, "preload12");
    step(1'b0, 32'd20, 32'd0, "preload20");
    step(1'b0, 32'd0,  32'd0, "preload0");

    step(1'b1, 32'd20, 32'd0, "rbw_old");
    step(1'b0, 32'd20, 32'd0, "store_new");
    step(1'b0, 32'd20, 32'd0, "store_hold");

    for (int i = 0; i < 3; i++) step(1'b0, 32'd12, 32'hDEAD_BEEF, "wr_disabled");

    step(1'b0, 32'd13, 32'd0,  "misalign_rd");
    step(1'b1, 32'd14, 32'hA5, "misalign_wr");
    step(1'b0, 32'd12, 32'd0,  "misalign_chk");

    step(1'b1, 32'd256, 32'd7, "oor_wr");
    step(1'b0, 32'd0,   32'd0, "no_alias");
    step(1'b0, 32'h0000_0FFC, 32'd0, "oor_high");

    step(1'b1, 32'd20, 32'h1234_5678, "pre_rst_wr");
    step(1'b1, 32'd24, 32'h9ABC_DEF0, "pre_rst_wr");
    step(1'b0, 32'd20, 32'd0,         "pre_rst_rd");
    reset_mid(32'd20, "async_rst");
    step(1'b1, 32'd20, 32'hFFFF_FFFF, "wr_in_rst");
    release_rst(32'd20, "post_rst");
    step(1'b0, 32'd24, 32'd0, "post_rst24");

    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1:       a = $urandom_range(256, 400);
        default: a = $urandom_range(0, 255);
      endcase
      if ($urandom_range(0, 99) < 2) begin
        reset_mid(a, "rnd_rst");
        release_rst($urandom_range(0, 255), "rnd_rel");
      end else begin
        step(1'($urandom_range(0, 1)), a, $urandom, "rnd");
      end
    end

    step(1'b0, 32'd0, 32'd0, "flush");
    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
